// File: rtl/fifo_audio_pkg.sv
// Shared types and constants for the FIFO-fed serial audio player.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_audio_pkg;

    typedef enum logic [1:0] {
        F_IDLE,
        F_REQ,
        F_WAIT
    } fetch_state_t;

    localparam int                UCNT_W   = 8;
    localparam logic [UCNT_W-1:0] UCNT_MAX = 8'd255;

endpackage

// File: rtl/audio_bit_timer.sv
// Free-running bit-slot timer; strobe marks the last clock of each slot.
// Latency: strobe is combinational from the count, first at CLKS_PER_BIT clocks after run rises.
// Backpressure: none; count is cleared whenever run is low.
module audio_bit_timer #(
    parameter int CLKS_PER_BIT = 50
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    output logic strobe
);

    localparam int            TW   = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset || !run) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign strobe = run && (cnt == LAST);

endmodule

// File: rtl/fifo_audio_player.sv
// Fetches words from the sample FIFO and shifts them MSB-first onto audio_out.
// Latency: fifo_rd 1 clk after enable & ~empty; first bit at first boundary after capture.
// Backpressure: one prefetch word; no FIFO read is issued while it is occupied.
module fifo_audio_player
    import fifo_audio_pkg::*;
#(
    parameter int   dbits        = 1,
    parameter int   CLKS_PER_BIT = 50,
    parameter int   RD_LAT       = 3,
    parameter logic IDLE_LEVEL   = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [dbits-1:0]  fifo_dout,
    output logic              fifo_rd,
    output logic              audio_out,
    output logic              bit_strobe,
    output logic              busy,
    output logic [UCNT_W-1:0] underrun_cnt
);

    localparam int             BLW       = (dbits > 1) ? $clog2(dbits) : 1;
    localparam logic [BLW-1:0] BL_INIT   = BLW'(dbits - 1);
    localparam int             WW        = $clog2(RD_LAT + 2);
    localparam logic [WW-1:0]  WAIT_LAST = WW'(RD_LAT);

    fetch_state_t     state;
    fetch_state_t     state_nxt;
    logic [WW-1:0]    wcnt;
    logic             capture;
    logic             bypass;
    logic             strobe;

    logic [dbits-1:0] shreg;
    logic [dbits-1:0] shreg_shift;
    logic [dbits-1:0] pre;
    logic             pre_valid;
    logic             playing;
    logic [BLW-1:0]   bits_left;

    assign busy        = playing || pre_valid || (state != F_IDLE);
    assign shreg_shift = shreg << 1;
    // A capture landing on an empty boundary skips the prefetch register.
    assign bypass      = capture && strobe && (bits_left == '0) && !pre_valid;

    audio_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clock (clock),
        .reset (reset),
        .run   (enable || busy),
        .strobe(strobe)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= F_IDLE;
            fifo_rd <= 1'b0;
        end else begin
            state   <= state_nxt;
            fifo_rd <= (state_nxt == F_REQ);
        end
    end

    // Counts clocks since fifo_rd dropped; capture once RD_LAT have elapsed.
    always_ff @(posedge clock) begin
        if (reset || state != F_WAIT) begin
            wcnt <= '0;
        end else begin
            wcnt <= wcnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            F_IDLE: begin
                if (enable && !fifo_empty && !pre_valid) begin
                    state_nxt = F_REQ;
                end
            end
            F_REQ: begin
                state_nxt = F_WAIT;
            end
            F_WAIT: begin
                if (wcnt == WAIT_LAST) begin
                    capture   = 1'b1;
                    state_nxt = F_IDLE;
                end
            end
            default: begin
                state_nxt = F_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            audio_out    <= IDLE_LEVEL;
            bit_strobe   <= 1'b0;
            underrun_cnt <= '0;
            shreg        <= '0;
            pre          <= '0;
            pre_valid    <= 1'b0;
            playing      <= 1'b0;
            bits_left    <= '0;
        end else begin
            bit_strobe <= strobe;
            if (strobe) begin
                if (bits_left != '0) begin
                    shreg     <= shreg_shift;
                    audio_out <= shreg_shift[dbits-1];
                    bits_left <= bits_left - 1'b1;
                end else if (pre_valid) begin
                    shreg     <= pre;
                    audio_out <= pre[dbits-1];
                    bits_left <= BL_INIT;
                    playing   <= 1'b1;
                    pre_valid <= 1'b0;
                end else if (capture) begin
                    shreg     <= fifo_dout;
                    audio_out <= fifo_dout[dbits-1];
                    bits_left <= BL_INIT;
                    playing   <= 1'b1;
                end else begin
                    audio_out <= IDLE_LEVEL;
                    playing   <= 1'b0;
                    // Starved slots only count while playback is requested.
                    if (enable && underrun_cnt != UCNT_MAX) begin
                        underrun_cnt <= underrun_cnt + 1'b1;
                    end
                end
            end
            if (capture && !bypass) begin
                pre       <= fifo_dout;
                pre_valid <= 1'b1;
            end
        end
    end

endmodule
